// File: rtl/regfile_dump_tx.sv
// Purpose : walks registers FIRST_REG..LAST_REG through a spare register-file read port and
//           serialises each 32-bit snapshot over UART 8N1, least-significant byte first.
// Latency : FETCH one cycle after an accepted start; each register takes 1 + 40*CLKS_PER_BIT cycles.
//           There is no backpressure: start is honoured only when busy=0, and a start seen while busy is dropped.
//
// Ports:
//   clk     - system clock; all state changes on posedge
//   AReset  - asynchronous active-low reset
//   start   - dump request, sampled on posedge while idle
//   rd_addr - register-file read address (the current register index)
//   rd_data - combinational read data for rd_addr
//   tx      - UART serial line, idle high
//   busy    - high while a dump is in progress
//   done    - one-cycle pulse in the first idle cycle after the last stop bit
module regfile_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic        clk,
    input  logic        AReset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [4:0]         idx_q, idx_d;
    logic [31:0]        shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               baud_last;
    logic [2:0]         next_bit;

    // Outputs are registered: the tx level for a bit slot is decided on the
    // edge that enters the slot, so tx never glitches between states.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        baud_last = (baud_q == BAUD_LAST);
        next_bit  = bit_q + 3'd1;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    idx_d   = FIRST_IDX;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Snapshot the whole word now; later register-file writes
                // cannot reach bytes still in flight.
                shift_d = rd_data;
                byte_d  = 2'd0;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = shift_q[next_bit];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q != 2'd3) begin
                        // Next byte of the same snapshot moves into the low lane.
                        byte_d  = byte_q + 2'd1;
                        shift_d = {8'h00, shift_q[31:8]};
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else if (idx_q != LAST_IDX) begin
                        // Compared before incrementing so index 31 never wraps to 0.
                        idx_d   = idx_q + 5'd1;
                        tx_d    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge AReset) begin
        if (!AReset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            idx_q   <= 5'd0;
            shift_q <= 32'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_addr = idx_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;

    localparam int CPB     = 4;
    localparam int REG_CYC = 1 + 40 * CPB;   // 161 cycles per register

    logic        clk = 1'b0;
    logic        areset_n;
    logic        start_s, start_f;
    logic [4:0]  addr_s, addr_f;
    logic [31:0] data_s, data_f;
    logic        tx_s, tx_f, busy_s, busy_f, done_s, done_f;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    assign data_s = regs[addr_s];
    assign data_f = regs[addr_f];

    // Single-register instance (reg 5 only) and full-range instance (0..31).
    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(5), .LAST_REG(5)) u_single (
        .clk(clk), .AReset(areset_n), .start(start_s), .rd_addr(addr_s),
        .rd_data(data_s), .tx(tx_s), .busy(busy_s), .done(done_s)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .AReset(areset_n), .start(start_f), .rd_addr(addr_f),
        .rd_data(data_f), .tx(tx_f), .busy(busy_f), .done(done_f)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0;
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          mod_rel;    // relative cycle of a mid-dump reg5 write, 0 = none
        logic [31:0] mod_val;
        logic [7:0]  e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance (on negedges) until the cycle relative to the accepting start is k.
    task automatic wait_rel(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    // Expected tx waveform of one 8N1 frame, one bit per clock, index 0 first.
    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [39:0] w;
        logic        v;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      v = 1'b0;
            else if (s == 9) v = 1'b1;
            else             v = b[s-1];
            for (int k = 0; k < CPB; k++) w[s*CPB + k] = v;
        end
        return w;
    endfunction

    task automatic capture(input bit full, input int rel, output logic [39:0] w);
        wait_rel(rel);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            w[i] = full ? tx_f : tx_s;
        end
    endtask

    task automatic kick(input bit full);
        @(negedge clk);
        if (full) start_f = 1'b1; else start_s = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_f = 1'b0;
        start_s = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] w;
        logic [7:0]  eb [4];
        vec_t        v;

        vecs[0] = '{"a5c30f81", 32'hA5C30F81, 0,   32'h0,        8'h81, 8'h0F, 8'hC3, 8'hA5};
        vecs[1] = '{"snapshot", 32'h11223344, 50,  32'hDEADBEEF, 8'h44, 8'h33, 8'h22, 8'h11};
        vecs[2] = '{"zeros",    32'h00000000, 0,   32'h0,        8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{"ones",     32'hFFFFFFFF, 0,   32'h0,        8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{"late_wr",  32'h12345678, 120, 32'h00000000, 8'h78, 8'h56, 8'h34, 8'h12};
        vecs[5] = '{"ends",     32'h80000001, 0,   32'h0,        8'h01, 8'h00, 8'h00, 8'h80};

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        start_s  = 1'b0;
        start_f  = 1'b0;
        areset_n = 1'b0;
        t0       = 0;

        // Reset held: outputs pinned while clk and start toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_s = i[0];
            start_f = ~i[0];
            check($sformatf("rst_hold_s[%0d]", i), 64'({tx_s, busy_s, done_s, addr_s}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
            check($sformatf("rst_hold_f[%0d]", i), 64'({tx_f, busy_f, done_f, addr_f}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
        end
        start_s  = 1'b0;
        start_f  = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle[%0d]", i), 64'({tx_s, busy_s, tx_f, busy_f}), 64'(4'b1010));
        end

        // Single-register vectors, including writes to reg5 mid-frame.
        for (int n = 0; n < 6; n++) begin
            v = vecs[n];
            eb = '{v.e0, v.e1, v.e2, v.e3};
            regs[5] = v.val;
            kick(1'b0);
            check({v.name, "_fetch"}, 64'({busy_s, addr_s}), 64'({1'b1, 5'd5}));
            fork
                begin
                    if (v.mod_rel > 0) begin
                        wait_rel(v.mod_rel);
                        regs[5] = v.mod_val;
                    end
                end
                begin
                    for (int b = 0; b < 4; b++) begin
                        capture(1'b0, 2 + 40 * b, w);
                        check($sformatf("%s_byte%0d", v.name, b), 64'(w), 64'(frame_wave(eb[b])));
                    end
                end
            join
            check({v.name, "_no_early_done"}, 64'({done_s, busy_s}), 64'(2'b01));
            wait_rel(162);
            check({v.name, "_done"}, 64'({done_s, busy_s}), 64'(2'b10));
            wait_rel(163);
            check({v.name, "_done_pulse"}, 64'(done_s), 64'(0));
        end

        // Full dump 0..31 with a stray start in the middle.
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
        kick(1'b1);
        fork
            begin
                wait_rel(700);
                start_f = 1'b1;
                @(negedge clk);
                start_f = 1'b0;
            end
            begin
                for (int r = 0; r < 32; r++) begin
                    wait_rel(1 + r * REG_CYC);
                    check($sformatf("full_addr%0d", r), 64'({busy_f, addr_f}), 64'({1'b1, 5'(r)}));
                    for (int b = 0; b < 4; b++) begin
                        capture(1'b1, 2 + r * REG_CYC + 40 * b, w);
                        check($sformatf("full_r%0d_b%0d", r, b), 64'(w), 64'(frame_wave(8'(r))));
                    end
                end
            end
        join
        // Start held high through the done cycle starts a second dump.
        start_f = 1'b1;
        wait_rel(5153);
        check("full_done", 64'({done_f, busy_f, addr_f}), 64'({1'b1, 1'b0, 5'd31}));
        @(negedge clk);
        check("restart_fetch", 64'({done_f, busy_f, addr_f}), 64'({1'b0, 1'b1, 5'd0}));
        start_f = 1'b0;
        t0 = t0 + 5153;

        // Reset during DATA bit 3 of byte 2 of reg 7 (byte 0x07, bit3 = 0).
        wait_rel(1226);
        check("pre_rst_midframe", 64'({tx_f, busy_f, addr_f}), 64'({1'b0, 1'b1, 5'd7}));
        areset_n = 1'b0;
        #1;
        check("async_rst", 64'({tx_f, busy_f, done_f, addr_f}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        check("after_rst_idle", 64'({tx_f, busy_f}), 64'(2'b10));
        kick(1'b1);
        check("rst_restart_fetch", 64'({busy_f, addr_f}), 64'({1'b1, 5'd0}));
        capture(1'b1, 2, w);
        check("rst_restart_byte0", 64'(w), 64'(frame_wave(8'h00)));
        wait_rel(1 + REG_CYC);
        check("rst_restart_reg1", 64'({busy_f, addr_f}), 64'({1'b1, 5'd1}));
        areset_n = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
